// File: rtl/mips_mem_port_pkg.sv
// mips_mem_port_pkg: shared types and constants for the MIPS memory port.
//   mem_op_t         - load/store operation encoding carried on req_op
//   mem_port_state_t - IDLE / BUS / RESP sequencing of one bus transaction
//   BE_*             - byte-enable patterns used by lane steering
//   op_is_*          - operation class helpers (store, halfword, word)
package mips_mem_port_pkg;

  typedef enum logic [3:0] {
    OP_LB  = 4'd0,
    OP_LBU = 4'd1,
    OP_LH  = 4'd2,
    OP_LHU = 4'd3,
    OP_LW  = 4'd4,
    OP_LWL = 4'd5,
    OP_LWR = 4'd6,
    OP_SB  = 4'd7,
    OP_SH  = 4'd8,
    OP_SW  = 4'd9
  } mem_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } mem_port_state_t;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_ALL     = 4'b1111;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;

  function automatic logic op_is_store(input mem_op_t op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic op_is_half(input mem_op_t op);
    return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  endfunction

  function automatic logic op_is_word(input mem_op_t op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mips_mem_port_load_align.sv
// mips_mem_port_load_align: combinational load result formation.
// Picks the addressed byte/halfword out of the fetched word, sign- or
// zero-extends it, or merges the word with the old rt value for LWL/LWR.
// Ports:
//   op_i     - operation (mem_op_t encoding)
//   o_i      - byte offset within the word (lane of the first byte)
//   word_i   - full 32-bit word returned by the bus
//   rt_old_i - current rt value, kept in the lanes LWL/LWR do not load
//   result_o - value written back to the register file
module mips_mem_port_load_align
  import mips_mem_port_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  o_i,
  input  logic [31:0] word_i,
  input  logic [31:0] rt_old_i,
  output logic [31:0] result_o
);

  mem_op_t     op;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] lwl_res;
  logic [31:0] lwr_res;

  always_comb begin
    op = mem_op_t'(op_i);

    case (o_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase

    // Halfword offsets are always even by the time they reach here.
    half_sel = o_i[1] ? word_i[31:16] : word_i[15:0];

    // LWL: bytes 0..o of the word land in the top of the register.
    case (o_i)
      2'd0:    lwl_res = {word_i[7:0],  rt_old_i[23:0]};
      2'd1:    lwl_res = {word_i[15:0], rt_old_i[15:0]};
      2'd2:    lwl_res = {word_i[23:0], rt_old_i[7:0]};
      default: lwl_res = word_i;
    endcase

    // LWR: bytes o..3 of the word land in the bottom of the register.
    case (o_i)
      2'd0:    lwr_res = word_i;
      2'd1:    lwr_res = {rt_old_i[31:24], word_i[31:8]};
      2'd2:    lwr_res = {rt_old_i[31:16], word_i[31:16]};
      default: lwr_res = {rt_old_i[31:8],  word_i[31:24]};
    endcase

    case (op)
      OP_LB:   result_o = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  result_o = {24'd0, byte_sel};
      OP_LH:   result_o = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  result_o = {16'd0, half_sel};
      OP_LWL:  result_o = lwl_res;
      OP_LWR:  result_o = lwr_res;
      default: result_o = word_i;
    endcase
  end

endmodule

// File: rtl/mips_mem_port.sv
// mips_mem_port: Avalon-MM master serving one core load/store at a time.
// Sequencing: IDLE -> BUS -> RESP -> IDLE (misaligned with error: IDLE -> RESP).
// Handshake: a request is taken on the clk edge where req_valid_i && req_ready_o;
//   req_ready_o is high only in IDLE, req_valid_i elsewhere is ignored. Each
//   accepted request yields exactly one resp_valid_o pulse; the Avalon side
//   completes on the first edge with waitrequest_i low.
// Ports:
//   clk, reset                    - clock, synchronous active-high reset
//   req_valid_i/req_ready_o       - request handshake
//   req_op_i, req_addr_i          - operation and byte address
//   req_wdata_i, req_rt_old_i     - store data, old rt for LWL/LWR merge
//   resp_valid_o/data_o/error_o   - one-cycle response
//   address_o, read_o, write_o, writedata_o, byteenable_o - Avalon outputs
//   waitrequest_i, readdata_i     - Avalon inputs
module mips_mem_port
  import mips_mem_port_pkg::*;
#(
  parameter int ADDR_W            = 32,
  parameter int TIMEOUT_CYCLES    = 256,
  parameter int ERROR_ON_MISALIGN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [3:0]        req_op_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic [31:0]       req_rt_old_i,
  output logic              resp_valid_o,
  output logic [31:0]       resp_data_o,
  output logic              resp_error_o,
  output logic [ADDR_W-1:0] address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              waitrequest_i,
  output logic [31:0]       writedata_o,
  output logic [3:0]        byteenable_o,
  input  logic [31:0]       readdata_i
);

  // One spare bit so the counter can hold TIMEOUT_CYCLES itself.
  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  mem_port_state_t   state_q, state_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        op_q, op_d;
  logic [1:0]        o_q, o_d;
  logic [31:0]       rt_old_q, rt_old_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_data_q, resp_data_d;
  logic              resp_error_q, resp_error_d;

  mem_op_t     req_op;
  logic [1:0]  req_o_eff;
  logic        misalign;
  logic [3:0]  req_be;
  logic [31:0] req_wd;
  logic [31:0] load_result;
  logic [CNT_W-1:0] cnt_inc;

  mips_mem_port_load_align u_load_align (
    .op_i     (op_q),
    .o_i      (o_q),
    .word_i   (readdata_i),
    .rt_old_i (rt_old_q),
    .result_o (load_result)
  );

  // Request decode: misalignment, effective offset, lanes and store data.
  always_comb begin
    req_op    = mem_op_t'(req_op_i);
    misalign  = 1'b0;
    req_o_eff = req_addr_i[1:0];
    if (op_is_half(req_op)) begin
      misalign     = req_addr_i[0];
      req_o_eff[0] = 1'b0;
    end else if (op_is_word(req_op)) begin
      misalign  = |req_addr_i[1:0];
      req_o_eff = 2'd0;
    end

    case (req_op)
      OP_SB:   req_be = 4'b0001 << req_o_eff;
      OP_SH:   req_be = req_o_eff[1] ? BE_HI_HALF : BE_LO_HALF;
      OP_LWL:  req_be = BE_ALL >> (2'd3 - req_o_eff);
      OP_LWR:  req_be = BE_ALL << req_o_eff;
      default: req_be = BE_ALL;
    endcase

    // Stores replicate their data across every lane they could hit.
    case (req_op)
      OP_SB:   req_wd = {4{req_wdata_i[7:0]}};
      OP_SH:   req_wd = {2{req_wdata_i[15:0]}};
      OP_SW:   req_wd = req_wdata_i;
      default: req_wd = 32'd0;
    endcase
  end

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    address_d    = address_q;
    read_d       = read_q;
    write_d      = write_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    op_d         = op_q;
    o_d          = o_q;
    rt_old_d     = rt_old_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_error_d = resp_error_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          if (misalign && (ERROR_ON_MISALIGN != 0)) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
            resp_data_d  = 32'd0;
          end else begin
            state_d   = ST_BUS;
            address_d = {req_addr_i[ADDR_W-1:2], 2'b00};
            be_d      = req_be;
            wdata_d   = req_wd;
            op_d      = req_op_i;
            o_d       = req_o_eff;
            rt_old_d  = req_rt_old_i;
            read_d    = !op_is_store(req_op);
            write_d   = op_is_store(req_op);
            cnt_d     = '0;
          end
        end
      end
      ST_BUS: begin
        if (!waitrequest_i) begin
          state_d      = ST_RESP;
          read_d       = 1'b0;
          write_d      = 1'b0;
          resp_valid_d = 1'b1;
          resp_error_d = 1'b0;
          resp_data_d  = op_is_store(mem_op_t'(op_q)) ? 32'd0 : load_result;
        end else begin
          cnt_d = cnt_inc;
          // Abort once this stalled cycle brings the count to the limit.
          if ((TIMEOUT_CYCLES != 0) && (cnt_inc == TO_LIMIT)) begin
            state_d      = ST_RESP;
            read_d       = 1'b0;
            write_d      = 1'b0;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
            resp_data_d  = 32'd0;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      address_q    <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      be_q         <= BE_NONE;
      wdata_q      <= 32'd0;
      op_q         <= 4'd0;
      o_q          <= 2'd0;
      rt_old_q     <= 32'd0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'd0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      address_q    <= address_d;
      read_q       <= read_d;
      write_q      <= write_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      op_q         <= op_d;
      o_q          <= o_d;
      rt_old_q     <= rt_old_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_error_q <= resp_error_d;
    end
  end

  assign req_ready_o  = (state_q == ST_IDLE);
  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign resp_error_o = resp_error_q;
  assign address_o    = address_q;
  assign read_o       = read_q;
  assign write_o      = write_q;
  assign writedata_o  = wdata_q;
  assign byteenable_o = be_q;

endmodule

// File: tb/tb_mips_mem_port.sv
// tb_mips_mem_port: scoreboard bench for mips_mem_port (TIMEOUT_CYCLES=4,
// ERROR_ON_MISALIGN=1). Driver tasks issue requests and play the Avalon
// slave; expected responses and bus beats go into queues that independent
// monitors pop and compare.
module tb_mips_mem_port;
  import mips_mem_port_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr, req_wdata, req_rt_old;
  logic        resp_valid, resp_error;
  logic [31:0] resp_data;
  logic [31:0] address;
  logic        read, write, waitrequest;
  logic [31:0] writedata, readdata;
  logic [3:0]  byteenable;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [32:0] exp_q[$];  // {error, data}
  logic [68:0] bus_q[$];  // {is_write, address, byteenable, writedata}
  logic        bus_act_prev = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mips_mem_port #(
    .ADDR_W(32), .TIMEOUT_CYCLES(TO), .ERROR_ON_MISALIGN(1)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_rt_old_i(req_rt_old),
    .resp_valid_o(resp_valid), .resp_data_o(resp_data), .resp_error_o(resp_error),
    .address_o(address), .read_o(read), .write_o(write),
    .waitrequest_i(waitrequest), .writedata_o(writedata),
    .byteenable_o(byteenable), .readdata_i(readdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_store(input mem_op_t op);
    return op == OP_SB || op == OP_SH || op == OP_SW;
  endfunction

  function automatic bit model_misaligned(input mem_op_t op, input logic [31:0] addr);
    int size;
    case (op)
      OP_LH, OP_LHU, OP_SH: size = 2;
      OP_LW, OP_SW:         size = 4;
      default:              size = 1;
    endcase
    return (addr % size) != 0;
  endfunction

  function automatic logic [3:0] model_be(input mem_op_t op, input int o);
    case (op)
      OP_SB:   return 4'(1 << o);
      OP_SH:   return 4'(3 << o);
      OP_LWL:  return 4'((1 << (o + 1)) - 1);
      OP_LWR:  return 4'(15 << o);
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input mem_op_t op, input logic [31:0] wd);
    case (op)
      OP_SB:   return (wd & 32'hFF) * 32'h01010101;
      OP_SH:   return (wd & 32'hFFFF) * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input mem_op_t op, input int o,
                                             input logic [31:0] w, input logic [31:0] old);
    int sh;
    logic [63:0] mask;
    sh = 8 * o;
    case (op)
      OP_LB:  return 32'($signed(8'(w >> sh)));
      OP_LBU: return 32'(8'(w >> sh));
      OP_LH:  return 32'($signed(16'(w >> sh)));
      OP_LHU: return 32'(16'(w >> sh));
      OP_LWL: begin
        sh   = 8 * (3 - o);
        mask = (64'd1 << sh) - 64'd1;
        return 32'((64'(w) << sh) | (64'(old) & mask));
      end
      OP_LWR: return (w >> sh) | (old & ~(32'hFFFF_FFFF >> sh));
      default: return w;
    endcase
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    logic [32:0] e;
    if (resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL resp_unexpected: got data 0x%08h err %0d expected no response",
                 resp_data, resp_error);
      end else begin
        e = exp_q.pop_front();
        chk("resp_error", 32'(resp_error), 32'(e[32]));
        chk("resp_data", resp_data, e[31:0]);
      end
    end
  end

  always @(negedge clk) begin
    logic [68:0] b;
    if (read === 1'b1 || write === 1'b1) begin
      if (bus_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL bus_unexpected: got read %0d write %0d addr 0x%08h expected idle bus",
                 read, write, address);
      end else begin
        b = bus_q[0];
        chk("bus_write", 32'(write), 32'(b[68]));
        chk("bus_read", 32'(read), 32'(!b[68]));
        chk("bus_address", address, b[67:36]);
        chk("bus_byteenable", 32'(byteenable), 32'(b[35:32]));
        if (b[68]) chk("bus_writedata", writedata, b[31:0]);
      end
    end
    if (bus_act_prev && !(read === 1'b1 || write === 1'b1) && bus_q.size() > 0)
      void'(bus_q.pop_front());
    bus_act_prev = (read === 1'b1 || write === 1'b1);
  end

  // ---------------- driver ----------------
  // Called at a negedge with the DUT idle; returns at a negedge with it idle.
  task automatic do_req(input mem_op_t op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] old, input logic [31:0] rword, input int waits);
    int  cyc;
    bit  st, to;
    int  o;
    st = model_store(op);
    o  = int'(addr[1:0]);
    req_valid  = 1'b1;
    req_op     = 4'(op);
    req_addr   = addr;
    req_wdata  = wd;
    req_rt_old = old;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_rt_old = $urandom;
    req_op     = 4'($urandom_range(0, 9));
    if (model_misaligned(op, addr)) begin
      exp_q.push_back({1'b1, 32'd0});
      @(negedge clk);
      chk("mis_resp_valid", 32'(resp_valid), 32'd1);
      chk("mis_ready_low", 32'(req_ready), 32'd0);
      @(negedge clk);
      chk("mis_ready_back", 32'(req_ready), 32'd1);
    end else begin
      to = (waits >= TO);
      bus_q.push_back({st, addr & 32'hFFFF_FFFC, model_be(op, o),
                       st ? model_wdata(op, wd) : 32'd0});
      exp_q.push_back(to ? {1'b1, 32'd0}
                         : {1'b0, st ? 32'd0 : model_load(op, o, rword, old)});
      cyc = 0;
      while (1) begin
        @(negedge clk);
        if (!(read === 1'b1 || write === 1'b1)) break;
        cyc++;
        if (cyc > 40) begin
          n_cmp++;
          n_fail++;
          $display("FAIL bus_hang: got %0d bus cycles expected at most %0d", cyc, TO);
          break;
        end
        waitrequest = (cyc <= waits);
        readdata    = waitrequest ? $urandom : rword;
        req_valid   = 1'($urandom_range(0, 1));
      end
      req_valid   = 1'b0;
      waitrequest = 1'($urandom_range(0, 1));
      readdata    = $urandom;
      chk("bus_cycles", 32'(cyc), 32'(to ? TO : waits + 1));
      chk("resp_after_bus", 32'(resp_valid), 32'd1);
      @(negedge clk);
      chk("ready_after_resp", 32'(req_ready), 32'd1);
    end
  endtask

  task automatic reset_mid_bus();
    req_valid  = 1'b1;
    req_op     = 4'(OP_LW);
    req_addr   = 32'h0000_5008;
    req_rt_old = 32'd0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    bus_q.push_back({1'b0, 32'h0000_5008, 4'hF, 32'd0});
    waitrequest = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_read", 32'(read), 32'd0);
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_address", address, 32'd0);
    chk("rst_byteenable", 32'(byteenable), 32'd0);
    waitrequest = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    mem_op_t op;
    int      w;
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_op      = 4'd0;
    req_addr    = 32'd0;
    req_wdata   = 32'd0;
    req_rt_old  = 32'd0;
    waitrequest = 1'b0;
    readdata    = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_read", 32'(read), 32'd0);
    chk("reset_write", 32'(write), 32'd0);
    chk("reset_address", address, 32'd0);
    chk("reset_byteenable", 32'(byteenable), 32'd0);
    chk("reset_writedata", writedata, 32'd0);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_resp_data", resp_data, 32'd0);
    chk("reset_resp_error", 32'(resp_error), 32'd0);
    chk("reset_ready", 32'(req_ready), 32'd1);
    reset = 1'b0;
    @(negedge clk);

    do_req(OP_LW,  32'hBFC0_0004, 32'd0, 32'd0, 32'h8C02_0010, 3);
    do_req(OP_LB,  32'h0000_1003, 32'd0, 32'd0, 32'h80FF_1234, 0);
    do_req(OP_LBU, 32'h0000_1003, 32'd0, 32'd0, 32'h80FF_1234, 1);
    do_req(OP_SH,  32'h0000_2002, 32'h0000_BEEF, 32'd0, 32'd0, 0);
    do_req(OP_LWL, 32'h0000_3001, 32'd0, 32'hAABB_CCDD, 32'h1122_3344, 0);
    do_req(OP_LWR, 32'h0000_3001, 32'd0, 32'hAABB_CCDD, 32'h1122_3344, 2);
    do_req(OP_LW,  32'h0000_4002, 32'd0, 32'd0, 32'd0, 0);
    do_req(OP_LW,  32'h0000_4000, 32'd0, 32'd0, 32'h1234_5678, 50);
    do_req(OP_SW,  32'h0000_4004, 32'hCAFE_F00D, 32'd0, 32'd0, TO - 1);
    reset_mid_bus();
    @(negedge clk);

    for (int i = 0; i < 300; i++) begin
      op = mem_op_t'($urandom_range(0, 9));
      w  = ($urandom_range(0, 9) == 0) ? TO + 1 : int'($urandom_range(0, 3));
      do_req(op, $urandom, $urandom, $urandom, $urandom, w);
    end

    repeat (3) @(negedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL global_timeout: got no finish expected finish before 500000");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "global timeout");
  end

endmodule
